// File: rtl/axi_xbar_cfg_ctrl.sv
// Crossbar reconfiguration controller: quiesces the slave ports, waits for
// outstanding transactions to drain, then swaps in a new rule or default port.
module axi_xbar_cfg_ctrl #(
    parameter int unsigned NoSlvPorts   = 4,
    parameter int unsigned NoMstPorts   = 4,
    parameter int unsigned NoAddrRules  = 4,
    parameter int unsigned RuleWidth    = 160,
    parameter int unsigned MaxTrans     = 8,
    parameter int unsigned DrainTimeout = 1024,
    localparam int unsigned IdxW  = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1,
    localparam int unsigned RIdxW = (NoAddrRules > 1) ? $clog2(NoAddrRules) : 1,
    localparam int unsigned CntW  = $clog2(MaxTrans + 1)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              cfg_valid_i,
    output logic                              cfg_ready_o,
    input  logic                              cfg_op_i,
    input  logic [RIdxW-1:0]                  cfg_rule_idx_i,
    input  logic [RuleWidth-1:0]              cfg_rule_i,
    input  logic [NoSlvPorts-1:0]             cfg_dflt_en_i,
    input  logic [NoSlvPorts*IdxW-1:0]        cfg_dflt_port_i,
    output logic                              cfg_err_o,
    input  logic [NoSlvPorts-1:0]             slv_aw_valid_i,
    input  logic [NoSlvPorts-1:0]             slv_aw_ready_i,
    input  logic [NoSlvPorts-1:0]             slv_ar_valid_i,
    input  logic [NoSlvPorts-1:0]             slv_ar_ready_i,
    input  logic [NoSlvPorts-1:0]             slv_b_valid_i,
    input  logic [NoSlvPorts-1:0]             slv_b_ready_i,
    input  logic [NoSlvPorts-1:0]             slv_r_valid_i,
    input  logic [NoSlvPorts-1:0]             slv_r_ready_i,
    input  logic [NoSlvPorts-1:0]             slv_r_last_i,
    output logic [NoSlvPorts-1:0]             slv_aw_block_o,
    output logic [NoSlvPorts-1:0]             slv_ar_block_o,
    output logic [NoAddrRules*RuleWidth-1:0]  addr_map_o,
    output logic [NoSlvPorts-1:0]             en_default_mst_port_o,
    output logic [NoSlvPorts*IdxW-1:0]        default_mst_port_o,
    output logic                              busy_o
);

    localparam int unsigned TmoW = (DrainTimeout > 1) ? $clog2(DrainTimeout) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLOCK = 2'd1,
        DRAIN = 2'd2,
        APPLY = 2'd3
    } state_e;

    state_e                      state_q, state_d;
    logic                        req_op_q, req_op_d;
    logic [RIdxW-1:0]            req_idx_q, req_idx_d;
    logic [RuleWidth-1:0]        req_rule_q, req_rule_d;
    logic [NoSlvPorts-1:0]       req_en_q, req_en_d;
    logic [NoSlvPorts*IdxW-1:0]  req_port_q, req_port_d;
    logic                        err_q, err_d;
    logic [TmoW-1:0]             tmo_q, tmo_d;
    logic                        cfg_ready_q, cfg_ready_d;
    logic                        cfg_err_q, cfg_err_d;
    logic                        busy_q, busy_d;
    logic [NoSlvPorts-1:0]       aw_block_q, aw_block_d;
    logic [NoSlvPorts-1:0]       ar_block_q, ar_block_d;
    logic [CntW-1:0]             wcnt_q [NoSlvPorts];
    logic [CntW-1:0]             wcnt_d [NoSlvPorts];
    logic [CntW-1:0]             rcnt_q [NoSlvPorts];
    logic [CntW-1:0]             rcnt_d [NoSlvPorts];
    logic [RuleWidth-1:0]        map_q [NoAddrRules];
    logic [RuleWidth-1:0]        map_d [NoAddrRules];
    logic [NoSlvPorts-1:0]       dflt_en_q, dflt_en_d;
    logic [NoSlvPorts*IdxW-1:0]  dflt_port_q, dflt_port_d;

    logic [NoSlvPorts-1:0] aw_hs, ar_hs, b_hs, rl_hs, aw_pend, ar_pend;
    logic                  all_idle, tmo_hit;

    assign aw_hs   = slv_aw_valid_i & slv_aw_ready_i;
    assign ar_hs   = slv_ar_valid_i & slv_ar_ready_i;
    assign b_hs    = slv_b_valid_i & slv_b_ready_i;
    assign rl_hs   = slv_r_valid_i & slv_r_ready_i & slv_r_last_i;
    assign aw_pend = slv_aw_valid_i & ~slv_aw_ready_i;
    assign ar_pend = slv_ar_valid_i & ~slv_ar_ready_i;
    assign tmo_hit = (tmo_q == TmoW'(DrainTimeout - 1));

    // Saturating outstanding-transaction counters per port and direction
    always_comb begin
        all_idle = 1'b1;
        for (int unsigned i = 0; i < NoSlvPorts; i++) begin
            wcnt_d[i] = wcnt_q[i];
            rcnt_d[i] = rcnt_q[i];
            if (aw_hs[i] && !b_hs[i] && wcnt_q[i] != CntW'(MaxTrans)) begin
                wcnt_d[i] = wcnt_q[i] + CntW'(1);
            end else if (!aw_hs[i] && b_hs[i] && wcnt_q[i] != '0) begin
                wcnt_d[i] = wcnt_q[i] - CntW'(1);
            end
            if (ar_hs[i] && !rl_hs[i] && rcnt_q[i] != CntW'(MaxTrans)) begin
                rcnt_d[i] = rcnt_q[i] + CntW'(1);
            end else if (!ar_hs[i] && rl_hs[i] && rcnt_q[i] != '0) begin
                rcnt_d[i] = rcnt_q[i] - CntW'(1);
            end
            if (wcnt_q[i] != '0 || rcnt_q[i] != '0) begin
                all_idle = 1'b0;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        req_op_d    = req_op_q;
        req_idx_d   = req_idx_q;
        req_rule_d  = req_rule_q;
        req_en_d    = req_en_q;
        req_port_d  = req_port_q;
        err_d       = err_q;
        tmo_d       = tmo_q;
        aw_block_d  = aw_block_q;
        ar_block_d  = ar_block_q;
        map_d       = map_q;
        dflt_en_d   = dflt_en_q;
        dflt_port_d = dflt_port_q;
        unique case (state_q)
            IDLE: begin
                if (cfg_valid_i) begin
                    req_op_d   = cfg_op_i;
                    req_idx_d  = cfg_rule_idx_i;
                    req_rule_d = cfg_rule_i;
                    req_en_d   = cfg_dflt_en_i;
                    req_port_d = cfg_dflt_port_i;
                    err_d      = 1'b0;
                    tmo_d      = '0;
                    state_d    = BLOCK;
                end
            end
            BLOCK: begin
                // A channel with a beat in flight is left open until it completes
                aw_block_d = aw_block_q | ~aw_pend;
                ar_block_d = ar_block_q | ~ar_pend;
                if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = APPLY;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                    if ((&aw_block_q) && (&ar_block_q)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (all_idle) begin
                    state_d = APPLY;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = APPLY;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            APPLY: begin
                if (!err_q) begin
                    if (req_op_q) begin
                        dflt_en_d   = req_en_q;
                        dflt_port_d = req_port_q;
                    end else begin
                        for (int unsigned r = 0; r < NoAddrRules; r++) begin
                            if (req_idx_q == RIdxW'(r)) begin
                                map_d[r] = req_rule_q;
                            end
                        end
                    end
                end
                aw_block_d = '0;
                ar_block_d = '0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        cfg_ready_d = (state_d == APPLY);
        cfg_err_d   = (state_d == APPLY) && err_d;
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            req_op_q    <= 1'b0;
            req_idx_q   <= '0;
            req_rule_q  <= '0;
            req_en_q    <= '0;
            req_port_q  <= '0;
            err_q       <= 1'b0;
            tmo_q       <= '0;
            cfg_ready_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            aw_block_q  <= '0;
            ar_block_q  <= '0;
            wcnt_q      <= '{default: '0};
            rcnt_q      <= '{default: '0};
            map_q       <= '{default: '0};
            dflt_en_q   <= '0;
            dflt_port_q <= '0;
        end else begin
            state_q     <= state_d;
            req_op_q    <= req_op_d;
            req_idx_q   <= req_idx_d;
            req_rule_q  <= req_rule_d;
            req_en_q    <= req_en_d;
            req_port_q  <= req_port_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
            cfg_ready_q <= cfg_ready_d;
            cfg_err_q   <= cfg_err_d;
            busy_q      <= busy_d;
            aw_block_q  <= aw_block_d;
            ar_block_q  <= ar_block_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            map_q       <= map_d;
            dflt_en_q   <= dflt_en_d;
            dflt_port_q <= dflt_port_d;
        end
    end

    for (genvar r = 0; r < NoAddrRules; r++) begin : g_map
        assign addr_map_o[r*RuleWidth +: RuleWidth] = map_q[r];
    end

    assign cfg_ready_o           = cfg_ready_q;
    assign cfg_err_o             = cfg_err_q;
    assign busy_o                = busy_q;
    assign slv_aw_block_o        = aw_block_q;
    assign slv_ar_block_o        = ar_block_q;
    assign en_default_mst_port_o = dflt_en_q;
    assign default_mst_port_o    = dflt_port_q;

`ifndef SYNTHESIS
    // Counter over/underflow means the crossbar broke its own handshake contract
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int unsigned i = 0; i < NoSlvPorts; i++) begin
                assert (!(aw_hs[i] && !b_hs[i] && wcnt_q[i] == CntW'(MaxTrans)))
                    else $error("write counter overflow on port %0d", i);
                assert (!(!aw_hs[i] && b_hs[i] && wcnt_q[i] == '0))
                    else $error("write counter underflow on port %0d", i);
                assert (!(ar_hs[i] && !rl_hs[i] && rcnt_q[i] == CntW'(MaxTrans)))
                    else $error("read counter overflow on port %0d", i);
                assert (!(!ar_hs[i] && rl_hs[i] && rcnt_q[i] == '0))
                    else $error("read counter underflow on port %0d", i);
            end
        end
    end
`endif

endmodule

// File: tb/tb_axi_xbar_cfg_ctrl.sv
// Directed bench for axi_xbar_cfg_ctrl: update latency, pending-beat blocking,
// read drain, timeout abort, simultaneous handshakes and mid-update reset.
module tb_axi_xbar_cfg_ctrl;

    localparam int unsigned NS = 4;
    localparam int unsigned RW = 160;
    localparam int unsigned CW = 640;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic           cfg_valid_i, cfg_ready_o, cfg_op_i, cfg_err_o, busy_o;
    logic [1:0]     cfg_rule_idx_i;
    logic [RW-1:0]  cfg_rule_i;
    logic [NS-1:0]  cfg_dflt_en_i, en_default_mst_port_o;
    logic [7:0]     cfg_dflt_port_i, default_mst_port_o;
    logic [NS-1:0]  aw_v, aw_r, ar_v, ar_r, b_v, b_r, r_v, r_r, r_l;
    logic [NS-1:0]  aw_blk, ar_blk;
    logic [4*RW-1:0] addr_map_o;

    int n_checks = 0;
    int n_errors = 0;
    logic [4*RW-1:0] exp_map;
    logic [RW-1:0]   r1, r2, r3, r4;

    axi_xbar_cfg_ctrl #(
        .NoSlvPorts(4), .NoMstPorts(4), .NoAddrRules(4), .RuleWidth(160),
        .MaxTrans(8), .DrainTimeout(16)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o), .cfg_op_i(cfg_op_i),
        .cfg_rule_idx_i(cfg_rule_idx_i), .cfg_rule_i(cfg_rule_i),
        .cfg_dflt_en_i(cfg_dflt_en_i), .cfg_dflt_port_i(cfg_dflt_port_i),
        .cfg_err_o(cfg_err_o),
        .slv_aw_valid_i(aw_v), .slv_aw_ready_i(aw_r),
        .slv_ar_valid_i(ar_v), .slv_ar_ready_i(ar_r),
        .slv_b_valid_i(b_v), .slv_b_ready_i(b_r),
        .slv_r_valid_i(r_v), .slv_r_ready_i(r_r), .slv_r_last_i(r_l),
        .slv_aw_block_o(aw_blk), .slv_ar_block_o(ar_blk),
        .addr_map_o(addr_map_o),
        .en_default_mst_port_o(en_default_mst_port_o),
        .default_mst_port_o(default_mst_port_o),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        r1 = {32'd1, 64'h0000_0000_1000_0000, 64'h0000_0000_1FFF_FFFF};
        r2 = {32'd2, 64'h0000_0000_2000_0000, 64'h0000_0000_2FFF_FFFF};
        r3 = {32'd3, 64'h0000_0000_3000_0000, 64'h0000_0000_3FFF_FFFF};
        r4 = {32'd0, 64'h0000_0000_4000_0000, 64'h0000_0000_4FFF_FFFF};
        exp_map = '0;
        rst_i = 1'b1;
        cfg_valid_i = 1'b0; cfg_op_i = 1'b0; cfg_rule_idx_i = '0; cfg_rule_i = '0;
        cfg_dflt_en_i = '0; cfg_dflt_port_i = '0;
        aw_v = '0; aw_r = '0; ar_v = '0; ar_r = '0;
        b_v = '0; b_r = '0; r_v = '0; r_r = '0; r_l = '0;

        // Reset values
        step(2);
        check("rst_ready", CW'(cfg_ready_o), CW'(0));
        check("rst_err", CW'(cfg_err_o), CW'(0));
        check("rst_busy", CW'(busy_o), CW'(0));
        check("rst_map", CW'(addr_map_o), CW'(0));
        check("rst_en", CW'(en_default_mst_port_o), CW'(0));
        check("rst_port", CW'(default_mst_port_o), CW'(0));
        check("rst_blk", CW'({aw_blk, ar_blk}), CW'(0));
        rst_i = 1'b0;
        step(1);

        // Idle crossbar, default-port write: ready at cycle 4, visible at cycle 5
        cfg_valid_i = 1'b1; cfg_op_i = 1'b1; cfg_dflt_en_i = 4'b0001; cfg_dflt_port_i = 8'h02;
        step(1);
        check("t1_busy_c1", CW'(busy_o), CW'(1));
        check("t1_ready_c1", CW'(cfg_ready_o), CW'(0));
        step(1);
        check("t1_awblk_c2", CW'(aw_blk), CW'(4'hF));
        check("t1_arblk_c2", CW'(ar_blk), CW'(4'hF));
        step(1);
        check("t1_ready_c3", CW'(cfg_ready_o), CW'(0));
        step(1);
        check("t1_ready_c4", CW'(cfg_ready_o), CW'(1));
        check("t1_err_c4", CW'(cfg_err_o), CW'(0));
        check("t1_en_c4", CW'(en_default_mst_port_o), CW'(0));
        step(1);
        check("t1_en_c5", CW'(en_default_mst_port_o), CW'(4'b0001));
        check("t1_port_c5", CW'(default_mst_port_o), CW'(8'h02));
        check("t1_blk_c5", CW'({aw_blk, ar_blk}), CW'(0));
        check("t1_ready_c5", CW'(cfg_ready_o), CW'(0));
        check("t1_busy_c5", CW'(busy_o), CW'(0));
        cfg_valid_i = 1'b0;
        step(1);

        // Port 1 AW pending through BLOCK; its block bit waits for the handshake
        cfg_valid_i = 1'b1; cfg_op_i = 1'b0; cfg_rule_idx_i = 2'd1; cfg_rule_i = r1;
        aw_v = 4'b0010; aw_r = 4'b0000;
        step(2);
        check("t2_awblk_c2", CW'(aw_blk), CW'(4'b1101));
        check("t2_arblk_c2", CW'(ar_blk), CW'(4'hF));
        step(3);
        check("t2_awblk_c5", CW'(aw_blk), CW'(4'b1101));
        aw_r = 4'b0010;
        step(1);
        check("t2_awblk_c6", CW'(aw_blk), CW'(4'hF));
        aw_v = '0; aw_r = '0;
        step(1);
        b_v = 4'b0010; b_r = 4'b0010;
        step(1);
        b_v = '0; b_r = '0;
        check("t2_ready_c8", CW'(cfg_ready_o), CW'(0));
        step(1);
        check("t2_ready_c9", CW'(cfg_ready_o), CW'(1));
        check("t2_err_c9", CW'(cfg_err_o), CW'(0));
        check("t2_map_c9", CW'(addr_map_o), CW'(exp_map));
        step(1);
        exp_map[1*RW +: RW] = r1;
        check("t2_map_c10", CW'(addr_map_o), CW'(exp_map));
        cfg_valid_i = 1'b0;
        step(1);

        // Three reads outstanding on port 2, drained by R-last beats
        ar_v = 4'b0100; ar_r = 4'b0100;
        step(3);
        ar_v = '0; ar_r = '0;
        step(1);
        cfg_valid_i = 1'b1; cfg_op_i = 1'b0; cfg_rule_idx_i = 2'd3; cfg_rule_i = r3;
        step(9);
        for (int k = 0; k < 3; k++) begin
            r_v = 4'b0100; r_r = 4'b0100; r_l = 4'b0100;
            step(1);
            r_v = '0; r_r = '0; r_l = '0;
            step(1);
        end
        check("t3_ready_c15", CW'(cfg_ready_o), CW'(1));
        check("t3_err_c15", CW'(cfg_err_o), CW'(0));
        step(1);
        exp_map[3*RW +: RW] = r3;
        check("t3_map_c16", CW'(addr_map_o), CW'(exp_map));
        cfg_valid_i = 1'b0;
        step(1);

        // Write on port 0 whose B never returns: drain times out
        aw_v = 4'b0001; aw_r = 4'b0001;
        step(1);
        aw_v = '0; aw_r = '0;
        cfg_valid_i = 1'b1; cfg_op_i = 1'b0; cfg_rule_idx_i = 2'd2; cfg_rule_i = r2;
        step(16);
        check("t4_ready_c16", CW'(cfg_ready_o), CW'(0));
        check("t4_busy_c16", CW'(busy_o), CW'(1));
        step(1);
        check("t4_ready_c17", CW'(cfg_ready_o), CW'(1));
        check("t4_err_c17", CW'(cfg_err_o), CW'(1));
        step(1);
        check("t4_map_c18", CW'(addr_map_o), CW'(exp_map));
        check("t4_blk_c18", CW'({aw_blk, ar_blk}), CW'(0));
        check("t4_err_c18", CW'(cfg_err_o), CW'(0));
        check("t4_en_c18", CW'(en_default_mst_port_o), CW'(4'b0001));
        cfg_valid_i = 1'b0;

        // Port 0: one more AW (count 2), then simultaneous AW+B keeps it at 2
        aw_v = 4'b0001; aw_r = 4'b0001;
        step(1);
        b_v = 4'b0001; b_r = 4'b0001;
        step(1);
        aw_v = '0; aw_r = '0; b_v = '0; b_r = '0;
        step(1);
        cfg_valid_i = 1'b1; cfg_op_i = 1'b1; cfg_dflt_en_i = 4'b1010; cfg_dflt_port_i = 8'hE4;
        step(3);
        b_v = 4'b0001; b_r = 4'b0001;
        step(1);
        b_v = '0; b_r = '0;
        step(1);
        check("t5_ready_c5", CW'(cfg_ready_o), CW'(0));
        b_v = 4'b0001; b_r = 4'b0001;
        step(1);
        b_v = '0; b_r = '0;
        check("t5_ready_c6", CW'(cfg_ready_o), CW'(0));
        step(1);
        check("t5_ready_c7", CW'(cfg_ready_o), CW'(1));
        step(1);
        check("t5_en_c8", CW'(en_default_mst_port_o), CW'(4'b1010));
        check("t5_port_c8", CW'(default_mst_port_o), CW'(8'hE4));
        cfg_valid_i = 1'b0;
        step(1);

        // Reset pulse while draining a write on port 3 aborts the update
        aw_v = 4'b1000; aw_r = 4'b1000;
        step(1);
        aw_v = '0; aw_r = '0;
        cfg_valid_i = 1'b1; cfg_op_i = 1'b0; cfg_rule_idx_i = 2'd0; cfg_rule_i = r4;
        step(4);
        check("t6_busy_c4", CW'(busy_o), CW'(1));
        rst_i = 1'b1; cfg_valid_i = 1'b0;
        step(1);
        rst_i = 1'b0;
        exp_map = '0;
        check("t6_busy_rst", CW'(busy_o), CW'(0));
        check("t6_ready_rst", CW'({cfg_ready_o, cfg_err_o}), CW'(0));
        check("t6_map_rst", CW'(addr_map_o), CW'(exp_map));
        check("t6_dflt_rst", CW'({en_default_mst_port_o, default_mst_port_o}), CW'(0));
        check("t6_blk_rst", CW'({aw_blk, ar_blk}), CW'(0));
        step(3);
        check("t6_map_after", CW'(addr_map_o), CW'(exp_map));
        check("t6_busy_after", CW'(busy_o), CW'(0));

        // Counters were cleared by reset, so a fresh update completes in 4 cycles
        cfg_valid_i = 1'b1;
        step(4);
        check("t7_ready_c4", CW'(cfg_ready_o), CW'(1));
        step(1);
        exp_map[0 +: RW] = r4;
        check("t7_map_c5", CW'(addr_map_o), CW'(exp_map));
        cfg_valid_i = 1'b0;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
